keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Drives the column lines of a 4x4 matrix keypad and samples its row lines.
- Uses the external debounce counter through its reset_count/count_done handshake to qualify both key press and key release.
- Emits a single-cycle key_valid strobe with a 4-bit key code once per debounced press.
- Sits between the keypad pins and the display/key-history logic of the Lab 3 design.

Parameters:
- SCAN_DIV, 16'd1000: clk cycles each column is held during idle scanning; legal range 4 to 65535.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rows  input  4  keypad row lines, active-low, pulled up externally, asynchronous to clk
- cols  output  4  column drive, active-low one-hot (exactly one bit low at all times after reset)
- reset_count  output  1  to debouncer: restart debounce interval
- count_done  input  1  from debouncer: debounce interval elapsed (one-cycle pulse)
- key_valid  output  1  one-cycle strobe, new debounced key
- key_code  output  4  code of last accepted key, held until next strobe
- key_held  output  1  high while an accepted key remains pressed, including release debounce

Behaviour:
- Input conditioning: rows passes through a 2-flop synchronizer; all decisions use the synchronized value rs. Flop reset value is 4'b1111.
- Row index: any_low = (rs != 4'b1111). row_idx = the lowest index i with rs[i]==0; multiple low rows resolve to the lowest index.
- Column index: col_idx (2 bits) selects cols = ~(4'b0001 << col_idx).
- Reset (async) values:
  - state=SCAN, col_idx=0, cols=4'b1110, scan counter=0
  - reset_count=1 (debouncer held cleared), key_valid=0, key_code=0, key_held=0
  - latched row/col = 0
- SCAN:
  - scan counter increments each cycle.
  - At SCAN_DIV-1: counter resets to 0 and col_idx increments mod 4 (3 wraps to 0).
  - If any_low and the counter >= 2 (settle window after a column change): latch row_idx and col_idx, go to DB_PRESS, assert reset_count for exactly that one transition cycle.
- DB_PRESS:
  - Column is frozen.
  - count_done is ignored in the first 2 cycles after reset_count deasserts (stale-pulse guard).
  - If rs[latched_row] goes high at any time: return to SCAN; counter=0, column unchanged.
  - On a qualified count_done with rs[latched_row] still low: go to PRESSED.
- PRESSED (1 cycle):
  - key_code <= encode(latched_row, latched_col); key_valid=1 for this cycle only; key_held <= 1.
  - Go to HOLD.
- HOLD:
  - Wait while rs[latched_row]==0; other keys are ignored (no rollover).
  - When rs[latched_row]==1: go to DB_RELEASE, pulse reset_count.
- DB_RELEASE:
  - Same 2-cycle count_done guard.
  - If rs[latched_row] returns low: back to HOLD, no new strobe.
  - On a qualified count_done with the row high: key_held <= 0, go to SCAN, counter=0, col_idx increments.
- reset_count is 0 in all cycles except reset and the single transition cycles named above.
- key_valid is never asserted on two consecutive cycles.
- A reset mid-debounce discards the latched key; no strobe is emitted.
- Default encode: key_code = {latched_row, latched_col}.

Optional Feature:
- Macro: KEY_HEX_MAP_EN.
- Defined: encode uses the board legend, rows 0..3 by cols 0..3:
  - row 0: 1, 2, 3, A
  - row 1: 4, 5, 6, B
  - row 2: 7, 8, 9, C
  - row 3: E, 0, F, D
  - key_code is the hex digit value, e.g. row 3 col 1 gives 4'h0, row 0 col 3 gives 4'hA.
- Undefined: raw {row,col} code; the mapping table is not synthesized.

Test Plan:
- Idle scan: SCAN_DIV=8, rows=4'hF, no press -> cols cycles 1110, 1101, 1011, 0111, 1110 at 8-cycle intervals; key_valid never asserted.
- Clean press, row 2 low while cols=1011: debouncer model returns count_done 20 cycles after reset_count -> exactly one key_valid; key_code=4'hA (raw {2,2}), or 4'h9 with KEY_HEX_MAP_EN; key_held=1.
- Bounce on press: row toggles low/high every 3 cycles for 15 cycles before settling low -> no strobe until settled plus a full debounce interval; exactly one strobe total.
- Bounce on release: held key released with 4 glitches back low -> no second strobe; key_held drops only after a full debounce with the row high; scanning resumes at the next column.
- Stale count_done: debouncer asserts count_done in the same cycle as reset_count and the following cycle -> ignored; strobe occurs only on the later pulse.
- Async reset asserted in DB_PRESS, between clock edges -> outputs reach their reset values immediately; no strobe; after release, scanning restarts with cols=1110.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, debounced press/release via external debouncer handshake.
// Optional KEY_HEX_MAP_EN maps {row,col} to the board legend hex digit instead of the raw code.
module keypad_scanner #(
  parameter logic [15:0] SCAN_DIV = 16'd1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       reset_count,
  input  logic       count_done,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  typedef enum logic [2:0] {
    SCAN       = 3'd0,
    DB_PRESS   = 3'd1,
    PRESSED    = 3'd2,
    HOLD       = 3'd3,
    DB_RELEASE = 3'd4
  } state_t;

  state_t      state_q;
  logic [3:0]  rows_meta_q;
  logic [3:0]  rs_q;
  logic [15:0] scan_cnt_q;
  logic [1:0]  col_idx_q;
  logic [1:0]  row_q;
  logic [1:0]  col_q;
  logic [1:0]  guard_q;
  logic        reset_count_q;
  logic        key_valid_q;
  logic [3:0]  key_code_q;
  logic        key_held_q;

  logic        any_low;
  logic [1:0]  row_idx;
  logic        row_up;
  logic        cd_ok;
  logic [3:0]  code_d;

  assign any_low = (rs_q != 4'b1111);
  assign row_up  = rs_q[row_q];
  // A done pulse is only trusted once the debouncer has seen two quiet cycles after its restart.
  assign cd_ok   = count_done && (guard_q == 2'd0);

  always_comb begin
    row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rs_q[i]) row_idx = 2'(i);
    end
  end

`ifdef KEY_HEX_MAP_EN
  always_comb begin
    code_d = 4'h0;
    case ({row_q, col_q})
      4'h0: code_d = 4'h1;
      4'h1: code_d = 4'h2;
      4'h2: code_d = 4'h3;
      4'h3: code_d = 4'hA;
      4'h4: code_d = 4'h4;
      4'h5: code_d = 4'h5;
      4'h6: code_d = 4'h6;
      4'h7: code_d = 4'hB;
      4'h8: code_d = 4'h7;
      4'h9: code_d = 4'h8;
      4'hA: code_d = 4'h9;
      4'hB: code_d = 4'hC;
      4'hC: code_d = 4'hE;
      4'hD: code_d = 4'h0;
      4'hE: code_d = 4'hF;
      4'hF: code_d = 4'hD;
      default: code_d = 4'h0;
    endcase
  end
`else
  assign code_d = {row_q, col_q};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SCAN;
      rows_meta_q   <= 4'b1111;
      rs_q          <= 4'b1111;
      scan_cnt_q    <= 16'd0;
      col_idx_q     <= 2'd0;
      row_q         <= 2'd0;
      col_q         <= 2'd0;
      guard_q       <= 2'd0;
      reset_count_q <= 1'b1;
      key_valid_q   <= 1'b0;
      key_code_q    <= 4'h0;
      key_held_q    <= 1'b0;
    end else begin
      rows_meta_q   <= rows;
      rs_q          <= rows_meta_q;
      reset_count_q <= 1'b0;
      key_valid_q   <= 1'b0;
      if (guard_q != 2'd0) guard_q <= guard_q - 2'd1;

      case (state_q)
        SCAN: begin
          // Rows lag a column change by the synchronizer depth, hence the settle window.
          if (any_low && (scan_cnt_q >= 16'd2)) begin
            row_q         <= row_idx;
            col_q         <= col_idx_q;
            reset_count_q <= 1'b1;
            guard_q       <= 2'd3;
            state_q       <= DB_PRESS;
          end else if (scan_cnt_q == SCAN_DIV - 16'd1) begin
            scan_cnt_q <= 16'd0;
            col_idx_q  <= col_idx_q + 2'd1;
          end else begin
            scan_cnt_q <= scan_cnt_q + 16'd1;
          end
        end
        DB_PRESS: begin
          if (row_up) begin
            scan_cnt_q <= 16'd0;
            state_q    <= SCAN;
          end else if (cd_ok) begin
            key_valid_q <= 1'b1;
            key_code_q  <= code_d;
            key_held_q  <= 1'b1;
            state_q     <= PRESSED;
          end
        end
        PRESSED: state_q <= HOLD;
        HOLD: begin
          if (row_up) begin
            reset_count_q <= 1'b1;
            guard_q       <= 2'd3;
            state_q       <= DB_RELEASE;
          end
        end
        DB_RELEASE: begin
          if (!row_up) begin
            state_q <= HOLD;
          end else if (cd_ok) begin
            key_held_q <= 1'b0;
            scan_cnt_q <= 16'd0;
            col_idx_q  <= col_idx_q + 2'd1;
            state_q    <= SCAN;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign cols        = ~(4'b0001 << col_idx_q);
  assign reset_count = reset_count_q;
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_held    = key_held_q;

endmodule
